// File: rtl/hyper_mon_pkg.sv
// Shared types and constants for the HyperBus monitor.
// HYPER_MON_RD_CNT_EN (defined) builds the per-chip read counters.
package hyper_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CA   = 2'd1,
    ST_XFER = 2'd2
  } hyper_mon_state_e;

  localparam int CaBytes   = 6;
  localparam int CaReadBit = 47;

  typedef logic [8*CaBytes-1:0] ca_t;

endpackage

// File: rtl/hyper_bus_monitor_if.sv
// HyperBus pin bundle as seen by the monitor: chip selects, CK and DQ per PHY.
// The monitor only listens; the bus side (master) owns every signal.
interface hyper_bus_monitor_if #(
  parameter int NumPhys  = 1,
  parameter int NumChips = 2
);
  logic [NumPhys-1:0][NumChips-1:0] hyper_cs_ni;
  logic [NumPhys-1:0]               hyper_ck_i;
  logic [NumPhys-1:0][7:0]          hyper_dq_i;

  modport master (output hyper_cs_ni, hyper_ck_i, hyper_dq_i);
  modport slave  (input  hyper_cs_ni, hyper_ck_i, hyper_dq_i);
endinterface

// File: rtl/hyper_mon_phy.sv
// One HyperBus PHY monitor: CS decode, IDLE/CA/XFER FSM, CA capture, per-chip counters.
// HYPER_MON_RD_CNT_EN (defined) adds the read counters; otherwise rd_cnt_o is 0.
module hyper_mon_phy
  import hyper_mon_pkg::*;
#(
  parameter int NumChips = 2,
  parameter int CntWidth = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic [NumChips-1:0]                cs_ni,
  input  logic                               ck_i,
  input  logic [7:0]                         dq_i,
  output logic [NumChips-1:0][CntWidth-1:0]  txn_cnt_o,
  output logic [NumChips-1:0][CntWidth-1:0]  rd_cnt_o,
  output ca_t                                ca_o,
  output logic                               ca_valid_o,
  output logic                               busy_o,
  output logic                               cs_conflict_o,
  output logic                               short_ca_o,
  output hyper_mon_state_e                   state_o
);

  localparam int IdxW = (NumChips > 1) ? $clog2(NumChips) : 1;

  hyper_mon_state_e         state_q, state_d;
  logic                     ck_q, armed_q, armed_d;
  logic [IdxW-1:0]          sel_q, sel_d, low_idx;
  logic [2:0]               byte_q, byte_d, low_cnt;
  logic [8*CaBytes-9:0]     hist_q, hist_d;
  ca_t                      ca_q, ca_word;
  logic                     ca_valid_q, conflict_q, short_q;
  logic                     ck_edge, multi, one_low, all_high, sel_rel, done, set_short;

  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < NumChips; i++) begin
      if (!cs_ni[i]) begin
        low_cnt = low_cnt + 3'd1;
        low_idx = IdxW'(i);
      end
    end
  end

  assign multi    = (low_cnt > 3'd1);
  assign one_low  = (low_cnt == 3'd1);
  assign all_high = (low_cnt == 3'd0);
  assign sel_rel  = cs_ni[sel_q];
  assign ck_edge  = ck_i ^ ck_q;
  assign ca_word  = {hist_q, dq_i};

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    byte_d    = byte_q;
    hist_d    = hist_q;
    done      = 1'b0;
    set_short = 1'b0;
    // Tracking is disarmed by reset or a conflict until every CS has been high.
    armed_d   = all_high ? 1'b1 : (multi ? 1'b0 : armed_q);
    if (multi) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (armed_q && one_low) begin
          state_d = ST_CA;
          sel_d   = low_idx;
          byte_d  = '0;
        end
        ST_CA: if (sel_rel) begin
          // A CK edge in the same cycle as CS release is not a byte.
          state_d   = ST_IDLE;
          set_short = 1'b1;
        end else if (ck_edge) begin
          hist_d = ca_word[8*CaBytes-9:0];
          byte_d = byte_q + 3'd1;
          if (byte_q == 3'(CaBytes - 1)) begin
            done    = 1'b1;
            state_d = ST_XFER;
          end
        end
        ST_XFER: if (sel_rel) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ck_q       <= 1'b0;
      armed_q    <= 1'b0;
      sel_q      <= '0;
      byte_q     <= '0;
      hist_q     <= '0;
      ca_q       <= '0;
      ca_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ck_q       <= ck_i;
      armed_q    <= armed_d;
      sel_q      <= sel_d;
      byte_q     <= byte_d;
      hist_q     <= hist_d;
      ca_valid_q <= done;
      if (done) ca_q <= ca_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= 1'b0;
      short_q    <= 1'b0;
    end else if (clear_i) begin
      conflict_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      conflict_q <= conflict_q | multi;
      short_q    <= short_q | set_short;
    end
  end

  for (genvar c = 0; c < NumChips; c++) begin : g_chip
    logic                hit;
    logic [CntWidth-1:0] txn_q;
    assign hit = done && (sel_q == IdxW'(c));

    // Saturating; clear takes priority over a coincident increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                 txn_q <= '0;
      else if (clear_i)            txn_q <= '0;
      else if (hit && txn_q != '1) txn_q <= txn_q + 1'b1;
    end
    assign txn_cnt_o[c] = txn_q;

`ifdef HYPER_MON_RD_CNT_EN
    logic [CntWidth-1:0] rd_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                     rd_q <= '0;
      else if (clear_i)                                rd_q <= '0;
      else if (hit && ca_word[CaReadBit] && rd_q != '1) rd_q <= rd_q + 1'b1;
    end
    assign rd_cnt_o[c] = rd_q;
`else
    assign rd_cnt_o[c] = '0;
`endif
  end

  assign ca_o          = ca_q;
  assign ca_valid_o    = ca_valid_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign cs_conflict_o = conflict_q;
  assign short_ca_o    = short_q;
  assign state_o       = state_q;

endmodule

// File: rtl/hyper_bus_monitor.sv
// Passive HyperBus monitor: one hyper_mon_phy per PHY, pins taken from hyper_bus_monitor_if.
// HYPER_MON_RD_CNT_EN (defined) enables rd_cnt_o; otherwise it reads 0.
module hyper_bus_monitor
  import hyper_mon_pkg::*;
#(
  parameter int NumPhys  = 1,
  parameter int NumChips = 2,
  parameter int CntWidth = 16
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            clear_i,
  hyper_bus_monitor_if.slave                              bus,
  output logic [NumPhys-1:0][NumChips-1:0][CntWidth-1:0]  txn_cnt_o,
  output logic [NumPhys-1:0][NumChips-1:0][CntWidth-1:0]  rd_cnt_o,
  // ca_valid_o is a one-cycle strobe qualifying ca_o; there is no back-pressure.
  output logic [NumPhys-1:0][47:0]                        ca_o,
  output logic [NumPhys-1:0]                              ca_valid_o,
  output logic [NumPhys-1:0]                              busy_o,
  output logic [NumPhys-1:0]                              cs_conflict_o,
  output logic [NumPhys-1:0]                              short_ca_o,
  output logic [NumPhys-1:0][1:0]                         dbg_state_o
);

  for (genvar p = 0; p < NumPhys; p++) begin : g_phy
    hyper_mon_state_e st;

    hyper_mon_phy #(
      .NumChips (NumChips),
      .CntWidth (CntWidth)
    ) u_phy (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .cs_ni         (bus.hyper_cs_ni[p]),
      .ck_i          (bus.hyper_ck_i[p]),
      .dq_i          (bus.hyper_dq_i[p]),
      .txn_cnt_o     (txn_cnt_o[p]),
      .rd_cnt_o      (rd_cnt_o[p]),
      .ca_o          (ca_o[p]),
      .ca_valid_o    (ca_valid_o[p]),
      .busy_o        (busy_o[p]),
      .cs_conflict_o (cs_conflict_o[p]),
      .short_ca_o    (short_ca_o[p]),
      .state_o       (st)
    );

    assign dbg_state_o[p] = st;
  end

endmodule
